// File: rtl/ctrl_spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_spi_slave_pkg
// Shared definitions for the ctrl SPI slave: default idle byte, default
// synchronizer depth, the frame state encoding and the ctrl register address
// map used by software-facing wrappers around the slave.
// -----------------------------------------------------------------------------
package ctrl_spi_slave_pkg;

   localparam logic [7:0] IDLE_BYTE_DEF   = 8'hff;
   localparam int         SYNC_STAGES_DEF = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

   // ctrl register address map
   localparam logic [3:0] CTRL_ADDR_STAT = 4'h0;
   localparam logic [3:0] CTRL_ADDR_TX   = 4'h1;
   localparam logic [3:0] CTRL_ADDR_RX   = 4'h2;
   localparam logic [3:0] CTRL_ADDR_CLR  = 4'h3;

endpackage

// File: rtl/ctrl_spi_slave_sync_edge.sv
// -----------------------------------------------------------------------------
// ctrl_sync_edge
// N-stage synchronizer for one asynchronous input, followed by an edge
// detector that compares the synchronized value against its registered
// previous value. rise/fall are registered 1-cycle pulses.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   din    asynchronous input
//   rise   1-cycle pulse on a synchronized 0->1 transition
//   fall   1-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module ctrl_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_p0;
   logic              prev_p1;

   // Reset value matches the input's idle level so release cannot fake an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= {STAGES{RST_VAL}};
         prev_p1 <= RST_VAL;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], din};
         // stage p1: edge detect against previous synchronized value
         prev_p1 <= sync_p0[STAGES-1];
         rise    <= sync_p0[STAGES-1] & ~prev_p1;
         fall    <= ~sync_p0[STAGES-1] & prev_p1;
      end
   end

endmodule

// File: rtl/ctrl_spi_slave.sv
// -----------------------------------------------------------------------------
// ctrl_spi_slave
// SPI mode-3 slave clocked entirely from the system clock. The SPI pins are
// oversampled through synchronizers; a single TX holding register feeds the
// out-shifter and the last received byte is presented with sticky flags.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_cs_n/clk/di     SPI pins from the master (asynchronous)
//   spi_do, spi_do_oe   MISO data and output enable
//   tx_dat/vld, tx_rdy  TX holding register write handshake
//   rx_dat, rx_vld      last received byte, sticky unread flag
//   rx_ack              clears rx_vld
//   rx_ovr, tx_urun     sticky overrun/underrun flags, cleared by stat_clr
//   sel, frm_end        frame active, 1-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module ctrl_spi_slave
   import ctrl_spi_slave_pkg::*;
#(
   parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_cs_n,
   input  logic       spi_clk,
   input  logic       spi_di,
   output logic       spi_do,
   output logic       spi_do_oe,
   input  logic [7:0] tx_dat,
   input  logic       tx_vld,
   output logic       tx_rdy,
   output logic [7:0] rx_dat,
   output logic       rx_vld,
   input  logic       rx_ack,
   output logic       rx_ovr,
   output logic       tx_urun,
   input  logic       stat_clr,
   output logic       sel,
   output logic       frm_end
);

   logic                   cs_rise, cs_fall;
   logic                   sck_rise, sck_fall;
   logic [SYNC_STAGES-1:0] di_sync;

   spi_state_t state;
   logic [2:0] bit_cnt;
   logic [7:0] osh;
   logic [6:0] ish;
   logic [7:0] hold_dat;
   logic       hold_full;
   logic       wr;
   logic       load;
   logic       sdi;

   ctrl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (spi_cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   ctrl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (spi_clk),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   // MOSI needs no edge detection, only the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         di_sync <= {SYNC_STAGES{1'b1}};
      end else begin
         di_sync <= {di_sync[SYNC_STAGES-2:0], spi_di};
      end
   end

   assign sdi = di_sync[SYNC_STAGES-1];
   assign wr  = tx_vld & ~hold_full;
   // Out-shifter reloads at frame start and at the rise completing each byte;
   // a CS rise in the same cycle ends the frame instead.
   assign load = ((state == ST_IDLE) && cs_fall) ||
                 ((state == ST_ACTIVE) && !cs_rise && sck_rise && (bit_cnt == 3'd7));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         osh       <= 8'hff;
         ish       <= 7'd0;
         hold_dat  <= 8'd0;
         hold_full <= 1'b0;
         rx_dat    <= 8'd0;
         rx_vld    <= 1'b0;
         rx_ovr    <= 1'b0;
         tx_urun   <= 1'b0;
         spi_do_oe <= 1'b0;
         frm_end   <= 1'b0;
      end else begin
         frm_end <= 1'b0;

         // Clears first so that a same-cycle set below overrides them
         if (stat_clr) begin
            rx_ovr  <= 1'b0;
            tx_urun <= 1'b0;
         end
         if (rx_ack) begin
            rx_vld <= 1'b0;
         end

         if (wr) begin
            hold_full <= 1'b1;
            hold_dat  <= tx_dat;
         end

         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state     <= ST_ACTIVE;
                  bit_cnt   <= 3'd0;
                  spi_do_oe <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  bit_cnt   <= 3'd0;
                  spi_do_oe <= 1'b0;
                  frm_end   <= 1'b1;
               end else if (sck_rise) begin
                  ish     <= {ish[5:0], sdi};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_dat <= {ish, sdi};
                     rx_vld <= 1'b1;
                     if (rx_vld) begin
                        rx_ovr <= 1'b1;
                     end
                  end
               end else if (sck_fall && (bit_cnt != 3'd0)) begin
                  // First fall of a byte keeps the freshly loaded MSB on the pin
                  osh <= {osh[6:0], 1'b1};
               end
            end
         endcase

         // A write never coincides with a full-register load, since wr needs it empty
         if (load) begin
            if (hold_full) begin
               osh       <= hold_dat;
               hold_full <= 1'b0;
            end else begin
               osh     <= IDLE_BYTE;
               tx_urun <= 1'b1;
            end
         end
      end
   end

   assign spi_do = osh[7];
   assign tx_rdy = ~hold_full;
   assign sel    = (state == ST_ACTIVE);

endmodule

// File: tb/tb_ctrl_spi_slave.sv
`timescale 1ns/1ps
module tb_ctrl_spi_slave;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_clk = 1'b1;
   logic       spi_di = 1'b1;
   logic       spi_do;
   logic       spi_do_oe;
   logic [7:0] tx_dat = 8'd0;
   logic       tx_vld = 1'b0;
   logic       tx_rdy;
   logic [7:0] rx_dat;
   logic       rx_vld;
   logic       rx_ack = 1'b0;
   logic       rx_ovr;
   logic       tx_urun;
   logic       stat_clr = 1'b0;
   logic       sel;
   logic       frm_end;

   int checks = 0;
   int errors = 0;
   int frm_cnt = 0;

   // Reference model: transaction-level view of the slave
   bit       m_full;
   bit [7:0] m_hold;
   bit [7:0] m_miso;
   bit       m_rx_vld;
   bit [7:0] m_rx_dat;
   bit       m_ovr;
   bit       m_urun;

   always #5 clk = ~clk;

   ctrl_spi_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_di   (spi_di),
      .spi_do   (spi_do),
      .spi_do_oe(spi_do_oe),
      .tx_dat   (tx_dat),
      .tx_vld   (tx_vld),
      .tx_rdy   (tx_rdy),
      .rx_dat   (rx_dat),
      .rx_vld   (rx_vld),
      .rx_ack   (rx_ack),
      .rx_ovr   (rx_ovr),
      .tx_urun  (tx_urun),
      .stat_clr (stat_clr),
      .sel      (sel),
      .frm_end  (frm_end)
   );

   always @(negedge clk) if (frm_end) frm_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_reset();
      m_full = 0; m_hold = 0; m_miso = 8'hff;
      m_rx_vld = 0; m_rx_dat = 0; m_ovr = 0; m_urun = 0;
   endtask

   task automatic m_load();
      if (m_full) begin
         m_miso = m_hold;
         m_full = 0;
      end else begin
         m_miso = 8'hff;
         m_urun = 1;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_spi_do"},  spi_do,    1);
      chk({tag, "_oe"},      spi_do_oe, 0);
      chk({tag, "_tx_rdy"},  tx_rdy,    1);
      chk({tag, "_rx_dat"},  rx_dat,    0);
      chk({tag, "_rx_vld"},  rx_vld,    0);
      chk({tag, "_rx_ovr"},  rx_ovr,    0);
      chk({tag, "_tx_urun"}, tx_urun,   0);
      chk({tag, "_sel"},     sel,       0);
      chk({tag, "_frm_end"}, frm_end,   0);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_rx_vld"},  rx_vld,  m_rx_vld);
      chk({tag, "_rx_dat"},  rx_dat,  m_rx_dat);
      chk({tag, "_rx_ovr"},  rx_ovr,  m_ovr);
      chk({tag, "_tx_urun"}, tx_urun, m_urun);
      chk({tag, "_tx_rdy"},  tx_rdy,  !m_full);
   endtask

   task automatic tx_write(input logic [7:0] d);
      chk("tx_rdy_before_wr", tx_rdy, 1);
      tx_dat = d;
      tx_vld = 1'b1;
      tick(1);
      tx_vld = 1'b0;
      m_full = 1;
      m_hold = d;
      chk("tx_rdy_after_wr", tx_rdy, 0);
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
      m_rx_vld = 0;
   endtask

   task automatic pulse_clr();
      stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
      m_ovr = 0; m_urun = 0;
   endtask

   task automatic frame_start();
      spi_cs_n = 1'b0;
      tick(8);
      m_load();
      chk("start_oe", spi_do_oe, 1);
      chk("start_sel", sel, 1);
   endtask

   task automatic frame_end(input string tag);
      int f0;
      f0 = frm_cnt;
      spi_cs_n = 1'b1;
      tick(8);
      chk({tag, "_frm_end_cnt"}, frm_cnt - f0, 1);
      chk({tag, "_oe_off"}, spi_do_oe, 0);
      chk({tag, "_sel_off"}, sel, 0);
   endtask

   // Mode-3 master: drive MOSI on SCK fall, sample MISO just before SCK rise.
   // ack_last places an rx_ack pulse in the cycle the last rise completes the byte.
   task automatic xfer(input string tag, input logic [7:0] mosi, input int h,
                       input int nbits, input bit ack_last);
      logic [7:0] got;
      got = 8'd0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_clk = 1'b0;
         spi_di  = mosi[i];
         tick(h);
         got[i]  = spi_do;
         spi_clk = 1'b1;
         if (ack_last && i == 0) begin
            tick(3);
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
            tick(h - 4);
         end else begin
            tick(h);
         end
      end
      if (nbits == 8) begin
         chk({tag, "_miso"}, got, m_miso);
         if (m_rx_vld) m_ovr = 1;
         m_rx_vld = 1;
         m_rx_dat = mosi;
         m_load();
      end
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] idle_do;
      int nb, h;

      m_reset();
      tick(3);
      chk_reset("rst");
      rst_n = 1'b1;
      tick(6);
      chk_reset("post_rst");

      // SCK/MOSI activity with CS high is ignored
      idle_do = spi_do;
      for (int i = 0; i < 16; i++) begin
         spi_clk = 1'b0; spi_di = 1'($urandom); tick(4);
         spi_clk = 1'b1; tick(4);
      end
      chk("idle_rx_vld", rx_vld, 0);
      chk("idle_spi_do", spi_do, idle_do);
      chk("idle_oe", spi_do_oe, 0);

      // Single byte with a queued A5; a second byte refills the register
      tx_write(8'hA5);
      frame_start();
      tx_write(8'($urandom));
      xfer("b3c", 8'h3C, 4, 8, 0);
      frame_end("f1");
      chk_state("f1");
      chk("f1_rx_dat_lit", rx_dat, 8'h3C);
      chk("f1_urun_lit", tx_urun, 0);
      pulse_ack();
      pulse_clr();

      // Two bytes, only 0x55 queued (register currently empty)
      tick(2);
      if (m_full) begin
         frame_start();
         frame_end("drain");
         pulse_clr();
      end
      tx_write(8'h55);
      frame_start();
      xfer("b12", 8'h12, 4, 8, 0);
      xfer("b34", 8'h34, 4, 8, 0);
      frame_end("f2");
      chk_state("f2");
      chk("f2_ovr_lit", rx_ovr, 1);
      chk("f2_urun_lit", tx_urun, 1);
      pulse_ack();
      pulse_clr();
      chk_state("f2_clr");

      // Aborted frame after 5 rises, then a clean frame
      frame_start();
      xfer("part", 8'($urandom), 4, 5, 0);
      frame_end("f3");
      chk_state("f3");
      frame_start();
      xfer("b81", 8'h81, 5, 8, 0);
      frame_end("f4");
      chk_state("f4");
      chk("f4_rx_dat_lit", rx_dat, 8'h81);
      pulse_ack();
      pulse_clr();

      // rx_ack coinciding with byte completion
      frame_start();
      xfer("ackc0", 8'($urandom), 4, 8, 1);
      chk("ackc0_rx_vld", rx_vld, 1);
      chk("ackc0_rx_ovr", rx_ovr, 0);
      xfer("ackc1", 8'($urandom), 4, 8, 1);
      chk("ackc1_rx_vld", rx_vld, 1);
      chk("ackc1_rx_ovr", rx_ovr, 1);
      frame_end("f5");
      chk_state("f5");
      pulse_ack();
      pulse_clr();

      // Reset mid-byte
      frame_start();
      xfer("prerst", 8'($urandom), 4, 3, 0);
      rst_n = 1'b0;
      spi_cs_n = 1'b1;
      spi_clk = 1'b1;
      spi_di = 1'b1;
      tick(1);
      chk_reset("midrst");
      tick(2);
      m_reset();
      rst_n = 1'b1;
      tick(6);
      frame_start();
      xfer("bc3", 8'hC3, 4, 8, 0);
      frame_end("f6");
      chk_state("f6");
      chk("f6_rx_dat_lit", rx_dat, 8'hC3);

      // Randomized frames
      for (int f = 0; f < 20; f++) begin
         h  = $urandom_range(6, 4);
         nb = $urandom_range(3, 1);
         if (!m_full && $urandom_range(1, 0) == 1) tx_write(8'($urandom));
         frame_start();
         for (int k = 0; k < nb; k++) begin
            if (!m_full && $urandom_range(1, 0) == 1) tx_write(8'($urandom));
            if ($urandom_range(3, 0) == 0) pulse_ack();
            b = 8'($urandom);
            xfer("rnd", b, h, 8, 0);
         end
         frame_end("rnd");
         chk_state("rnd");
         if ($urandom_range(2, 0) == 0) pulse_clr();
         if ($urandom_range(1, 0) == 0) pulse_ack();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
